regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count (power of two, 8..64); index width AW = log2(NREGS).
REQ-003 Parameter NRD, default 3, read port count (ports for Rs, Rt, Rp).
REQ-004 Parameter NWR, default 1, write port count (1..2).
REQ-005 Parameter PROT_REG, default 30, write-protected register index.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW].
REQ-009 rd_en  input  NRD  read port i is in use (takes part in hazard check).
REQ-010 rd_data  output  NRD*XLEN  read data per port.
REQ-011 rd_zero  output  NRD  read data of port i equals 0 (predicate test).
REQ-012 wr_en  input  NWR  write enable per write port.
REQ-013 wr_addr  input  NWR*AW  write addresses.
REQ-014 wr_data  input  NWR*XLEN  write data.
REQ-015 iss_valid  input  1  an instruction with a register destination is issuing this cycle.
REQ-016 iss_rd  input  AW  destination of the issuing instruction.
REQ-017 flush  input  1  clear all pending bits (KILL of in-flight work).
REQ-018 busy  output  NRD  port i address has a pending write.
REQ-019 stall  output  1  OR over i of (rd_en[i] & busy[i]).
REQ-020 pend_cnt  output  AW+1  number of registers with a pending write.

Function
REQ-021 Reads are combinational; address 0 shall always return 0.
REQ-022 Writes occur on the clk rising edge; writes to register 0 or PROT_REG shall be ignored.
REQ-023 When two write ports target the same register in one cycle, the higher-index port's data shall be written.
REQ-024 Pending bit p[r] shall be set at the edge when iss_valid=1 and iss_rd=r, for r not 0 and not PROT_REG.
REQ-025 p[r] shall be cleared at the edge when any wr_en port writes r and no issue to r occurs in the same cycle.
REQ-026 Simultaneous issue and writeback to the same r: set shall win, so p[r] stays 1 (new producer).
REQ-027 flush=1 shall clear every pending bit at the edge and override any issue in that cycle.
REQ-028 busy[i] = p[rd_addr[i]] & ~(write to rd_addr[i] this cycle); address 0 shall never be busy.
REQ-029 rd_zero[i] shall be 0 when rd_addr[i]=0 (R0 means "always execute").
REQ-030 pend_cnt shall equal the population count of p, registered, updated in the same edge as p.
REQ-031 A write with wr_en=0 shall have no effect on the array or on p.

Reset
REQ-032 While reset=0, all registers shall be 0, all p bits 0, and pend_cnt 0, independent of clk.
REQ-033 All outputs shall be valid combinationally during reset (rd_data 0, busy 0, stall 0).
REQ-034 Writes and issues presented during reset shall be discarded; operation resumes on the first edge after deassertion.

Configuration
REQ-035 Macro REGFILE_BYPASS_EN: when defined, a read of a register being written the same cycle shall return the (highest-index) wr_data; when undefined, it shall return the stored value.
REQ-036 busy behaviour (REQ-028) shall be identical with and without REGFILE_BYPASS_EN; without bypass, the hazard unit is responsible for the extra cycle.

Structure
REQ-037 Shared package regfile_pkg shall hold the defaults for XLEN, NREGS, PROT_REG and the index-width function.
REQ-038 The scoreboard (p bits, pend_cnt, busy logic) shall be a sub-module named rf_scoreboard.

Verification
REQ-039 Reset is low, then high; write R5=0x1234, then read R5 -> rd_data=0x1234; write R0=7 and R30=9 -> both read back 0.
REQ-040 Issue rd=4, then read R4 with rd_en=1 -> busy=1, stall=1, pend_cnt=1; write R4=0xA -> busy=0 in the same cycle, and p cleared after the edge.
REQ-041 In one cycle, issue rd=6 and write R6 -> p[6] stays 1 and pend_cnt is unchanged.
REQ-042 With NWR=2, both ports write R3 (0x11 and 0x22) -> R3=0x22.
REQ-043 Issue rd=2,3,7 and then flush -> pend_cnt=0 and all busy=0; an async reset mid-sequence clears everything without a clock.
REQ-044 Read R9 while writing R9=0x55: with REGFILE_BYPASS_EN -> 0x55 and rd_zero=0; without it -> the old value 0 and rd_zero=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NREGS_DEF    = 32;
    localparam int unsigned PROT_REG_DEF = 30;

    // Register index width for a power-of-two register count.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, its population count,
// and per-read-port busy/stall hazard outputs.
module rf_scoreboard import regfile_pkg::*; #(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 3,
    parameter int unsigned NWR      = 1,
    parameter int unsigned PROT_REG = PROT_REG_DEF,
    localparam int unsigned AW      = idx_width(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NRD-1:0]    rd_en_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic              flush_i,
    output logic [NRD-1:0]    busy_o,
    output logic              stall_o,
    output logic [AW:0]       pend_cnt_o
);

    logic [NREGS-1:0] pend_q, pend_d;
    logic [NREGS-1:0] wr_hit, iss_hit;
    logic [AW:0]      cnt_q, cnt_d;
    logic [AW-1:0]    ra;

    // Decode this cycle's writebacks and issue into per-register hit vectors.
    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) wr_hit[wr_addr_i[j*AW +: AW]] = 1'b1;
        end
        if (iss_valid_i && (iss_rd_i != '0) && (iss_rd_i != AW'(PROT_REG))) begin
            iss_hit[iss_rd_i] = 1'b1;
        end
    end

    // Next pending state: issue beats writeback (new producer), flush beats all.
    always_comb begin
        pend_d = flush_i ? '0 : ((pend_q & ~wr_hit) | iss_hit);
        cnt_d  = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[r]);
        end
    end

    // Pending bits and their count share one edge so they never disagree.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // A writeback landing this cycle resolves the hazard for its readers.
    always_comb begin
        busy_o = '0;
        ra     = '0;
        for (int i = 0; i < NRD; i++) begin
            ra        = rd_addr_i[i*AW +: AW];
            busy_o[i] = (ra != '0) && pend_q[ra] && !wr_hit[ra];
        end
    end

    assign stall_o    = |(rd_en_i & busy_o);
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with write-protected R0/PROT_REG and an attached
// pending-write scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle
// write data to readers; otherwise reads return the stored value.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 3,
    parameter int unsigned NWR      = 1,
    parameter int unsigned PROT_REG = PROT_REG_DEF,
    localparam int unsigned AW      = idx_width(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic [NRD-1:0]      rd_en,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_zero,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [NRD-1:0]      busy,
    output logic                stall,
    output logic [AW:0]         pend_cnt
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [NWR-1:0]  wr_ok;
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    // A write port only lands outside reset and away from R0 and PROT_REG.
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_ok[j] = reset && wr_en[j] && (wr_addr[j*AW +: AW] != '0) &&
                       (wr_addr[j*AW +: AW] != AW'(PROT_REG));
        end
    end

    // Storage array; later ports override earlier ones on address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j]) mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        rd_data = '0;
        rd_zero = '0;
        ra      = '0;
        rv      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            rv = (ra == '0) ? '0 : mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j] && (wr_addr[j*AW +: AW] == ra)) rv = wr_data[j*XLEN +: XLEN];
            end
`endif
            rd_data[i*XLEN +: XLEN] = rv;
            rd_zero[i]              = (ra != '0) && (rv == '0);
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .PROT_REG (PROT_REG)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (reset),
        .rd_addr_i   (rd_addr),
        .rd_en_i     (rd_en),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .flush_i     (flush),
        .busy_o      (busy),
        .stall_o     (stall),
        .pend_cnt_o  (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (NWR=2). Expectations follow the
// REGFILE_BYPASS_EN setting of the build.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 3;
    localparam int unsigned NWR   = 2;
    localparam int unsigned PROT  = 30;
    localparam int unsigned AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_en;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_zero;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic [NRD-1:0]      busy;
    logic                stall;
    logic [AW:0]         pend_cnt;

    regfile_scoreboard #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .PROT_REG (PROT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_zero   (rd_zero),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {KData, KZero, KBusy, KStall, KPend} kind_e;
    typedef struct {
        kind_e       kind;
        int          port;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] observe(input kind_e k, input int p);
        case (k)
            KData:   return rd_data[p*XLEN +: XLEN];
            KZero:   return 32'(rd_zero[p]);
            KBusy:   return 32'(busy[p]);
            KStall:  return 32'(stall);
            default: return 32'(pend_cnt);
        endcase
    endfunction

    task automatic expect_val(input kind_e k, input int p, input logic [31:0] v, input string tag);
        exp_t e;
        e.kind = k;
        e.port = p;
        e.val  = v;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.kind, e.port), e.val);
        end
    endtask

    task automatic clear_inputs();
        rd_en     = '0;
        wr_en     = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
        rd_en[p]            = 1'b1;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_addr[p*AW +: AW]     = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
        wr_en[p]                = 1'b1;
    endtask

    task automatic issue(input int r);
        iss_valid = 1'b1;
        iss_rd    = AW'(r);
    endtask

    // Compare queued expectations half a cycle before the committing edge.
    task automatic sample();
        @(negedge clk);
        drain();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        wr_addr = '0;
        iss_rd  = '0;
        clear_inputs();
        #1 reset = 1'b0;

        // Activity during reset must be invisible and discarded.
        wr(0, 5, 32'hdead);
        issue(4);
        rd(0, 5);
        rd(1, 4);
        #2;
        expect_val(KData, 0, 32'h0, "rst_rd_data");
        expect_val(KBusy, 1, 32'h0, "rst_busy");
        expect_val(KStall, 0, 32'h0, "rst_stall");
        expect_val(KPend, 0, 32'h0, "rst_pend");
        drain();
        step();
        reset = 1'b1;

        // Basic write/read, reset leftovers absent.
        wr(0, 5, 32'h1234);
        step();
        rd(0, 5);
        expect_val(KData, 0, 32'h1234, "r5_read");
        expect_val(KZero, 0, 32'h0, "r5_zero");
        expect_val(KPend, 0, 32'h0, "pend_after_rst");
        sample();
        step();

        // R0 and the protected register ignore writes.
        wr(0, 0, 32'h7);
        wr(1, PROT, 32'h9);
        step();
        rd(0, 0);
        rd(1, PROT);
        expect_val(KData, 0, 32'h0, "r0_read");
        expect_val(KData, 1, 32'h0, "rprot_read");
        expect_val(KZero, 0, 32'h0, "r0_zero");
        expect_val(KZero, 1, 32'h1, "rprot_zero");
        sample();
        step();

        // Issue to R4 creates a hazard.
        issue(4);
        step();
        rd(0, 4);
        rd(1, 5);
        expect_val(KBusy, 0, 32'h1, "r4_busy");
        expect_val(KBusy, 1, 32'h0, "r5_not_busy");
        expect_val(KStall, 0, 32'h1, "r4_stall");
        expect_val(KPend, 0, 32'h1, "r4_pend");
        sample();
        step();

        // Writeback resolves the hazard in its own cycle.
        rd(0, 4);
        wr(0, 4, 32'hA);
        expect_val(KBusy, 0, 32'h0, "r4_wb_busy");
        expect_val(KStall, 0, 32'h0, "r4_wb_stall");
        expect_val(KPend, 0, 32'h1, "r4_wb_pend");
        expect_val(KData, 0, Bypass ? 32'hA : 32'h0, "r4_wb_data");
        sample();
        step();
        rd(0, 4);
        expect_val(KBusy, 0, 32'h0, "r4_done_busy");
        expect_val(KPend, 0, 32'h0, "r4_done_pend");
        expect_val(KData, 0, 32'hA, "r4_done_data");
        sample();
        step();

        // Issue and writeback to R6 together: the pending bit survives.
        issue(6);
        step();
        issue(6);
        wr(0, 6, 32'h66);
        rd(0, 6);
        expect_val(KPend, 0, 32'h1, "r6_pend_pre");
        expect_val(KBusy, 0, 32'h0, "r6_wb_busy");
        sample();
        step();
        rd(0, 6);
        expect_val(KPend, 0, 32'h1, "r6_pend_kept");
        expect_val(KBusy, 0, 32'h1, "r6_busy_kept");
        expect_val(KStall, 0, 32'h1, "r6_stall_kept");
        expect_val(KData, 0, 32'h66, "r6_data");
        sample();
        step();
        wr(1, 6, 32'h67);
        step();
        rd(0, 6);
        expect_val(KPend, 0, 32'h0, "r6_pend_clr");
        expect_val(KData, 0, 32'h67, "r6_port1_data");
        sample();
        step();

        // Same-cycle collision: higher port wins.
        wr(0, 3, 32'h11);
        wr(1, 3, 32'h22);
        step();
        rd(2, 3);
        expect_val(KData, 2, 32'h22, "r3_collision");
        sample();
        step();

        // Several pending, then flush overriding a simultaneous issue.
        issue(2);
        step();
        issue(3);
        step();
        issue(7);
        step();
        rd(0, 2);
        rd(1, 3);
        rd(2, 7);
        flush = 1'b1;
        issue(9);
        expect_val(KPend, 0, 32'h3, "pend_three");
        expect_val(KBusy, 0, 32'h1, "r2_busy");
        expect_val(KBusy, 1, 32'h1, "r3_busy");
        expect_val(KBusy, 2, 32'h1, "r7_busy");
        expect_val(KStall, 0, 32'h1, "multi_stall");
        sample();
        step();
        rd(0, 2);
        rd(1, 3);
        rd(2, 7);
        expect_val(KPend, 0, 32'h0, "flush_pend");
        expect_val(KBusy, 0, 32'h0, "flush_busy0");
        expect_val(KBusy, 1, 32'h0, "flush_busy1");
        expect_val(KBusy, 2, 32'h0, "flush_busy2");
        expect_val(KStall, 0, 32'h0, "flush_stall");
        sample();
        step();

        // Issues to R0 and the protected register never become pending.
        issue(PROT);
        step();
        issue(0);
        step();
        rd(0, PROT);
        expect_val(KPend, 0, 32'h0, "prot_issue_pend");
        expect_val(KBusy, 0, 32'h0, "prot_issue_busy");
        sample();
        step();

        // Read during write of R9.
        rd(0, 9);
        wr(0, 9, 32'h55);
        expect_val(KData, 0, Bypass ? 32'h55 : 32'h0, "r9_bypass_data");
        expect_val(KZero, 0, Bypass ? 32'h0 : 32'h1, "r9_bypass_zero");
        sample();
        step();
        rd(0, 9);
        expect_val(KData, 0, 32'h55, "r9_data");
        expect_val(KZero, 0, 32'h0, "r9_zero");
        sample();
        step();

        // Disabled write port touches neither array nor pending bit.
        issue(9);
        step();
        wr_addr[0 +: AW]   = AW'(9);
        wr_data[0 +: XLEN] = 32'hdead;
        rd(0, 9);
        expect_val(KBusy, 0, 32'h1, "wr_dis_busy");
        expect_val(KPend, 0, 32'h1, "wr_dis_pend_pre");
        sample();
        step();
        rd(0, 9);
        expect_val(KData, 0, 32'h55, "wr_dis_data");
        expect_val(KPend, 0, 32'h1, "wr_dis_pend");
        sample();
        step();

        // Asynchronous reset mid-sequence, checked between clock edges.
        issue(2);
        step();
        #2 reset = 1'b0;
        #1;
        rd(0, 5);
        rd(1, 9);
        #0;
        expect_val(KPend, 0, 32'h0, "async_rst_pend");
        expect_val(KData, 0, 32'h0, "async_rst_data");
        expect_val(KBusy, 1, 32'h0, "async_rst_busy");
        expect_val(KStall, 0, 32'h0, "async_rst_stall");
        drain();
        step();
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
